// File: rtl/mm_slave_pkg.sv
// Shared types and helpers for the bus_MM slave memory (mm_slave_mem).
package mm_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } mm_slv_state_t;

  localparam int WAIT_MAX = 15;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mm_slave_ram.sv
// Register array with asynchronous clear, one write port and one registered read port.
module mm_slave_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage array: cleared on reset, written on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: samples the pre-write contents, so same-edge writes are never bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/mm_slave_mem.sv
// bus_MM slave: 2^ADDR_W x DATA_W memory with WAIT_CYCLES wait states per access.
// Optional accepted-write counter port wr_count enabled by macro MM_SLAVE_WRCNT_EN.
module mm_slave_mem
  import mm_slave_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 32'd0,
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
`ifdef MM_SLAVE_WRCNT_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  // Value stall_cnt reaches on the last STALL cycle; IDLE already accounts for one wait state.
  localparam logic [3:0] STALL_END_C = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

  mm_slv_state_t state_r, state_nxt_s;
  logic [3:0]    stall_cnt_r, stall_cnt_nxt_s;
  logic          request_s, accept_s, wr_en_s, rd_en_s;

  assign request_s   = write | read;
  assign wr_en_s     = accept_s & write;
  assign rd_en_s     = accept_s & read & ~write;
  assign waitrequest = request_s & ~accept_s;

  // FSM and stall counter registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      stall_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
    end
  end

  // Next-state, stall counting and accept decode.
  always_comb begin
    state_nxt_s     = state_r;
    stall_cnt_nxt_s = stall_cnt_r;
    accept_s        = 1'b0;
    case (state_r)
      IDLE: begin
        stall_cnt_nxt_s = 4'd0;
        if (!request_s) begin
          state_nxt_s = IDLE;
        end else if (WAIT_CYCLES == 32'd0) begin
          accept_s = 1'b1;
        end else if (WAIT_CYCLES == 32'd1) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = STALL;
        end
      end
      STALL: begin
        if (!request_s) begin
          state_nxt_s     = IDLE;
          stall_cnt_nxt_s = 4'd0;
        end else begin
          stall_cnt_nxt_s = stall_cnt_r + 4'd1;
          if (stall_cnt_nxt_s == STALL_END_C) begin
            state_nxt_s = ACK;
          end else begin
            state_nxt_s = STALL;
          end
        end
      end
      ACK: begin
        accept_s        = request_s;
        state_nxt_s     = IDLE;
        stall_cnt_nxt_s = 4'd0;
      end
      default: begin
        state_nxt_s     = IDLE;
        stall_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // One-cycle valid pulse following an accepted (non-dropped) read.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_en_s;
    end
  end

`ifdef MM_SLAVE_WRCNT_EN
  // Saturating count of accepted writes.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= 16'd0;
    end else if (wr_en_s) begin
      wr_count <= sat_inc16(wr_count);
    end
  end
`endif

  mm_slave_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (reset_n),
    .wr_en   (wr_en_s),
    .wr_addr (address),
    .wr_data (writedata),
    .rd_en   (rd_en_s),
    .rd_addr (address),
    .rd_data (readdata)
  );

endmodule

// File: tb/tb_mm_slave_mem.sv
// Self-checking bench: three mm_slave_mem instances (0, 3 and 2 wait states) against an array model.
module tb_mm_slave_mem;

  localparam int WAITS [3] = '{0, 3, 2};

  logic       CLK;
  logic       rst_n   [3];
  logic [7:0] addr    [3];
  logic       wr      [3];
  logic [7:0] wdata   [3];
  logic       rd      [3];
  logic       waitreq [3];
  logic [7:0] rdata   [3];
  logic       rdv     [3];
`ifdef MM_SLAVE_WRCNT_EN
  logic [15:0] wrc    [3];
`endif

  logic [7:0]  ref_mem [3][256];
  logic [15:0] ref_wrc [3];
  int checks = 0;
  int errors = 0;

  mm_slave_mem #(.WAIT_CYCLES(32'd0), .ADDR_W(8), .DATA_W(8)) u0 (
    .CLK(CLK), .reset_n(rst_n[0]), .address(addr[0]), .write(wr[0]), .writedata(wdata[0]),
    .read(rd[0]), .waitrequest(waitreq[0]), .readdata(rdata[0]), .readdatavalid(rdv[0])
`ifdef MM_SLAVE_WRCNT_EN
    , .wr_count(wrc[0])
`endif
  );
  mm_slave_mem #(.WAIT_CYCLES(32'd3), .ADDR_W(8), .DATA_W(8)) u1 (
    .CLK(CLK), .reset_n(rst_n[1]), .address(addr[1]), .write(wr[1]), .writedata(wdata[1]),
    .read(rd[1]), .waitrequest(waitreq[1]), .readdata(rdata[1]), .readdatavalid(rdv[1])
`ifdef MM_SLAVE_WRCNT_EN
    , .wr_count(wrc[1])
`endif
  );
  mm_slave_mem #(.WAIT_CYCLES(32'd2), .ADDR_W(8), .DATA_W(8)) u2 (
    .CLK(CLK), .reset_n(rst_n[2]), .address(addr[2]), .write(wr[2]), .writedata(wdata[2]),
    .read(rd[2]), .waitrequest(waitreq[2]), .readdata(rdata[2]), .readdatavalid(rdv[2])
`ifdef MM_SLAVE_WRCNT_EN
    , .wr_count(wrc[2])
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input int k);
    for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'h00;
    ref_wrc[k] = 16'h0000;
  endtask

  // One bus access; the model decides wait count, stored data and read response.
  task automatic access(input int k, input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    int   waits;
    logic got;
    waits = 0;
    got   = 1'b0;
    addr[k] = a; wdata[k] = d; wr[k] = w; rd[k] = r;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK);
      if (waitreq[k]) begin
        waits++;
        @(posedge CLK); #1;
      end else begin
        got = 1'b1;
      end
    end
    check($sformatf("u%0d accepted a=%0h", k, a), 32'(got), 32'd1);
    check($sformatf("u%0d wait_states a=%0h", k, a), 32'(waits), 32'(WAITS[k]));
    @(posedge CLK); #1;
    wr[k] = 1'b0; rd[k] = 1'b0;
    if (w) begin
      ref_mem[k][a] = d;
      if (ref_wrc[k] != 16'hFFFF) ref_wrc[k] = ref_wrc[k] + 16'd1;
    end
    @(negedge CLK);
    check($sformatf("u%0d readdatavalid a=%0h", k, a), 32'(rdv[k]), 32'(r && !w));
    if (r && !w) check($sformatf("u%0d readdata a=%0h", k, a), 32'(rdata[k]), 32'(ref_mem[k][a]));
`ifdef MM_SLAVE_WRCNT_EN
    check($sformatf("u%0d wr_count", k), 32'(wrc[k]), 32'(ref_wrc[k]));
`endif
    @(posedge CLK); #1;
    check($sformatf("u%0d rdv_single_pulse", k), 32'(rdv[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; addr[k] = 8'h00; wr[k] = 1'b0; wdata[k] = 8'h00; rd[k] = 1'b0;
      clear_model(k);
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d reset readdata", k), 32'(rdata[k]), 32'd0);
      check($sformatf("u%0d reset rdv", k), 32'(rdv[k]), 32'd0);
      check($sformatf("u%0d reset waitreq", k), 32'(waitreq[k]), 32'd0);
`ifdef MM_SLAVE_WRCNT_EN
      check($sformatf("u%0d reset wr_count", k), 32'(wrc[k]), 32'd0);
`endif
    end
    @(negedge CLK);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge CLK); #1;

    // Zero wait states: write/idle pattern then read back.
    for (int i = 0; i < 4; i++) access(0, 1'b1, 1'b0, 8'(i), 8'(i));
    for (int i = 0; i < 4; i++) access(0, 1'b0, 1'b1, 8'(i), 8'h00);

    // Three wait states.
    access(1, 1'b1, 1'b0, 8'h10, 8'hA5);
    access(1, 1'b0, 1'b1, 8'h10, 8'h00);

    // Write and read together: write wins, read dropped.
    access(0, 1'b1, 1'b1, 8'h20, 8'h5A);
    access(0, 1'b0, 1'b1, 8'h20, 8'h00);

    // Reset in the middle of a stalled write.
    addr[2] = 8'h30; wdata[2] = 8'hFF; wr[2] = 1'b1;
    @(negedge CLK);
    check("u2 stall waitreq", 32'(waitreq[2]), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    wr[2] = 1'b0; rst_n[2] = 1'b0;
    #1;
    check("u2 midreset readdata", 32'(rdata[2]), 32'd0);
    check("u2 midreset rdv", 32'(rdv[2]), 32'd0);
    check("u2 midreset waitreq", 32'(waitreq[2]), 32'd0);
    clear_model(2);
    @(negedge CLK);
    rst_n[2] = 1'b1;
    @(posedge CLK); #1;
    access(2, 1'b0, 1'b1, 8'h30, 8'h00);

    // Top address cell, and neighbour at zero untouched.
    access(0, 1'b1, 1'b0, 8'hFF, 8'hC3);
    access(0, 1'b0, 1'b1, 8'hFF, 8'h00);
    access(0, 1'b0, 1'b1, 8'h00, 8'h00);

    // Reset right after a read accept must kill the pending valid pulse.
    access(0, 1'b1, 1'b0, 8'h40, 8'h77);
    addr[0] = 8'h40; rd[0] = 1'b1;
    @(posedge CLK); #1;
    rd[0] = 1'b0;
    check("u0 rdv before reset", 32'(rdv[0]), 32'd1);
    check("u0 rdata before reset", 32'(rdata[0]), 32'h77);
    rst_n[0] = 1'b0;
    #1;
    check("u0 rdv cleared by reset", 32'(rdv[0]), 32'd0);
    check("u0 rdata cleared by reset", 32'(rdata[0]), 32'd0);
    clear_model(0);
    @(negedge CLK);
    rst_n[0] = 1'b1;
    @(posedge CLK); #1;
    access(0, 1'b0, 1'b1, 8'h40, 8'h00);

    // Randomised accesses on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 30; n++) begin
        int op;
        logic [7:0] a;
        op = $urandom_range(0, 3);
        a  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        case (op)
          0, 1: access(k, 1'b1, 1'b0, a, 8'($urandom));
          2:    access(k, 1'b0, 1'b1, a, 8'h00);
          default: access(k, 1'b1, 1'b1, a, 8'($urandom));
        endcase
      end
    end

`ifdef MM_SLAVE_WRCNT_EN
    // Drive the counter to FFFE with back-to-back writes, then check saturation.
    rst_n[0] = 1'b0;
    clear_model(0);
    @(negedge CLK);
    rst_n[0] = 1'b1;
    @(posedge CLK); #1;
    addr[0] = 8'h00; wdata[0] = 8'h00; wr[0] = 1'b1;
    repeat (65534) @(posedge CLK);
    #1;
    wr[0] = 1'b0;
    ref_wrc[0] = 16'hFFFE;
    check("u0 wr_count preload", 32'(wrc[0]), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) access(0, 1'b1, 1'b0, 8'(i), 8'(8'h11 + i));
    check("u0 wr_count saturated", 32'(wrc[0]), 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
